// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit seven-segment scan controller with frame-coherent snapshot.
// Optional anti-ghosting blank interval between digits is built when SCAN_BLANK_EN is defined.
module display_scan_controller #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] AplusB,
    input  logic [3:0] AminusB,
    input  logic       update_req,
    input  logic [3:0] digit_en,
    output logic       update_ack,
    output logic [3:0] A_q,
    output logic [3:0] B_q,
    output logic [3:0] AplusB_q,
    output logic [3:0] AminusB_q,
    output logic [3:0] anode,
    output logic [1:0] slot,
    output logic       frame_start
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

`ifdef SCAN_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    typedef enum logic [1:0] {ARM, DRIVE, BLANK} state_t;
    logic [BW-1:0] blank_cnt, blank_cnt_nxt;
`else
    typedef enum logic [1:0] {ARM, DRIVE} state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    slot_i, slot_nxt;
    logic [3:0]    anode_d;
    logic          frame_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARM;
            cnt       <= '0;
            slot_i    <= 2'd0;
`ifdef SCAN_BLANK_EN
            blank_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            slot_i    <= slot_nxt;
`ifdef SCAN_BLANK_EN
            blank_cnt <= blank_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        slot_nxt      = slot_i;
`ifdef SCAN_BLANK_EN
        blank_cnt_nxt = blank_cnt;
`endif
        case (state)
            ARM: begin
                state_nxt = DRIVE;
                cnt_nxt   = '0;
                slot_nxt  = 2'd0;
            end
            DRIVE: begin
                if (cnt == CW'(PRESCALE - 1)) begin
                    cnt_nxt = '0;
`ifdef SCAN_BLANK_EN
                    state_nxt     = BLANK;
                    blank_cnt_nxt = '0;
`else
                    slot_nxt = slot_i + 2'd1;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
                    blank_cnt_nxt = '0;
                    state_nxt     = DRIVE;
                    slot_nxt      = slot_i + 2'd1;
                end else begin
                    blank_cnt_nxt = blank_cnt + BW'(1);
                end
            end
`endif
            default: state_nxt = ARM;
        endcase
    end

    // Moore outputs of the current state; registered below so every output lags state by one clock
    always_comb begin
        anode_d = 4'b1111;
        frame_d = 1'b0;
        if (state == DRIVE) begin
            if (digit_en[slot_i]) begin
                anode_d = ~(4'b0001 << slot_i);
            end
            frame_d = (slot_i == 2'd0) && (cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode       <= 4'b1111;
            slot        <= 2'd0;
            frame_start <= 1'b0;
            update_ack  <= 1'b0;
            A_q         <= 4'd0;
            B_q         <= 4'd0;
            AplusB_q    <= 4'd0;
            AminusB_q   <= 4'd0;
        end else begin
            anode       <= anode_d;
            slot        <= slot_i;
            frame_start <= frame_d;
            update_ack  <= frame_d && update_req;
            // Snapshot only moves on the edge that starts a new frame
            if (frame_d && update_req) begin
                A_q       <= A;
                B_q       <= B;
                AplusB_q  <= AplusB;
                AminusB_q <= AminusB;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - scoreboard bench for display_scan_controller.
module tb_display_scan_controller;

    localparam int P  = 4;
    localparam int BL = 2;
`ifdef SCAN_BLANK_EN
    localparam int D = P + BL;
`else
    localparam int D = P;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] A, B, AplusB, AminusB;
    logic       update_req;
    logic [3:0] digit_en;
    logic       update_ack;
    logic [3:0] A_q, B_q, AplusB_q, AminusB_q;
    logic [3:0] anode;
    logic [1:0] slot;
    logic       frame_start;

    display_scan_controller #(.PRESCALE(P), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .A(A), .B(B), .AplusB(AplusB), .AminusB(AminusB),
        .update_req(update_req), .digit_en(digit_en),
        .update_ack(update_ack),
        .A_q(A_q), .B_q(B_q), .AplusB_q(AplusB_q), .AminusB_q(AminusB_q),
        .anode(anode), .slot(slot), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: outputs follow from the number of clock edges since reset release
    int          cyc       = 0;
    logic [3:0]  exp_anode = 4'hF;
    logic [1:0]  exp_slot  = 2'd0;
    logic        exp_fs    = 1'b0;
    logic [15:0] model_q   = 16'h0;
    logic [15:0] sb[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc       = 0;
            model_q   = 16'h0;
            sb.delete();
            exp_anode = 4'hF;
            exp_slot  = 2'd0;
            exp_fs    = 1'b0;
        end else begin
            cyc++;
            if (cyc < 2) begin
                exp_anode = 4'hF;
                exp_slot  = 2'd0;
                exp_fs    = 1'b0;
            end else begin
                int p, s, w;
                logic [3:0] onehot;
                p = cyc - 2;
                s = (p / D) % 4;
                w = p % D;
                onehot    = 4'b0001 << s;
                exp_anode = (w < P && digit_en[s]) ? ~onehot : 4'hF;
                exp_slot  = s[1:0];
                exp_fs    = (p % (4 * D)) == 0;
                if (exp_fs && update_req) begin
                    model_q = {A, B, AplusB, AminusB};
                    sb.push_back(model_q);
                end
            end
        end
    end

    // Monitor: compares on the opposite edge, pops the scoreboard whenever an ack is presented
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_anode", {28'h0, anode}, 32'hF);
            chk("reset_slot", {30'h0, slot}, 32'h0);
            chk("reset_frame_start", {31'h0, frame_start}, 32'h0);
            chk("reset_ack", {31'h0, update_ack}, 32'h0);
            chk("reset_snapshot", {16'h0, A_q, B_q, AplusB_q, AminusB_q}, 32'h0);
        end else begin
            chk("anode", {28'h0, anode}, {28'h0, exp_anode});
            chk("slot", {30'h0, slot}, {30'h0, exp_slot});
            chk("frame_start", {31'h0, frame_start}, {31'h0, exp_fs});
            if (update_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'h1, 32'h0);
                end else begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    chk("snapshot_on_ack", {16'h0, A_q, B_q, AplusB_q, AminusB_q}, {16'h0, e});
                end
            end else if (sb.size() != 0) begin
                chk("missing_ack", 32'h0, 32'h1);
                sb.delete();
            end
            chk("snapshot_stable", {16'h0, A_q, B_q, AplusB_q, AminusB_q}, {16'h0, model_q});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack_then_drop();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 * D + 8; i++) begin
            step();
            if (update_ack) begin
                seen = 1'b1;
                break;
            end
        end
        update_req = 1'b0;
        if (!seen) chk("ack_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        rst_n      = 1'b0;
        A          = 4'd0;
        B          = 4'd0;
        AplusB     = 4'd0;
        AminusB    = 4'd0;
        update_req = 1'b0;
        digit_en   = 4'hF;
        repeat (3) step();
        rst_n = 1'b1;

        // Two full frames of plain scanning with all digits enabled
        repeat (8 * D + 2) step();

        // Request raised mid slot 1, held until acknowledged
        while (exp_slot != 2'd1) step();
        step();
        A = 4'd5; B = 4'd3; AplusB = 4'd8; AminusB = 4'd2;
        update_req = 1'b1;
        wait_ack_then_drop();
        repeat (4 * D) step();

        // Single-cycle withdrawn request in slot 2, inputs wander mid-frame
        while (exp_slot != 2'd2) step();
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        for (int i = 0; i < 4 * D; i++) begin
            A = 4'($urandom);
            AminusB = 4'($urandom);
            step();
        end

        // Digit mask
        digit_en = 4'b0101;
        repeat (8 * D) step();
        digit_en = 4'hF;

        // Randomized traffic with a well-behaved requester that occasionally withdraws or re-requests
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                A       = 4'($urandom);
                B       = 4'($urandom);
                AplusB  = 4'($urandom);
                AminusB = 4'($urandom);
            end
            if ($urandom_range(0, 29) == 0) digit_en = 4'($urandom);
            if (update_req && update_ack) begin
                if ($urandom_range(0, 7) != 0) update_req = 1'b0;
            end else if (!update_req && $urandom_range(0, 19) == 0) begin
                update_req = 1'b1;
            end else if (update_req && $urandom_range(0, 39) == 0) begin
                update_req = 1'b0;
            end
            step();
        end
        update_req = 1'b0;
        repeat (2) step();

        // Asynchronous reset in slot 2 with a request pending
        while (exp_slot != 2'd2) step();
        update_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_anode", {28'h0, anode}, 32'hF);
        chk("async_reset_snapshot", {16'h0, A_q, B_q, AplusB_q, AminusB_q}, 32'h0);
        chk("async_reset_ack", {31'h0, update_ack}, 32'h0);
        repeat (2) step();
        update_req = 1'b0;
        rst_n = 1'b1;
        repeat (12 * D) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing controller for the 4-digit seven-segment display of the calculator lab. It steps the active-low anode one-cold across digits 0–3 at a programmable refresh rate and optionally inserts an anti-ghosting blank interval between digits. It also holds a frame-coherent snapshot of the four displayed nibbles, which is updated through a request/acknowledge handshake only at frame boundaries. Its outputs drive the anode/value inputs of `seven_seg_decoder`.

## Interface
- `PRESCALE`, default 100000: clocks each digit is driven; legal range ≥ 2.
- `BLANK_CYCLES`, default 1000: clocks of all-off between digits; legal range ≥ 1; used only with `SCAN_BLANK_EN`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A`, `B`, `AplusB`, `AminusB`  in  4 each  candidate display values.
- `update_req`  in  1  level request to load a new snapshot.
- `digit_en`  in  4  per-digit enable, active high; bit i controls digit i.
- `update_ack`  out  1  one-cycle pulse: snapshot loaded.
- `A_q`, `B_q`, `AplusB_q`, `AminusB_q`  out  4 each  registered snapshot fed to the decoder.
- `anode`  out  4  registered, active-low, at most one bit low.
- `slot`  out  2  index of the current or most recent digit.
- `frame_start`  out  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- FSM states: ARM, DRIVE, BLANK. BLANK exists only with `SCAN_BLANK_EN`.
- ARM is entered on reset and lasts one cycle. `anode`=4'b1111. It exits to DRIVE with slot 0, which is a frame boundary.
- DRIVE:
  - Prescale counter runs 0..`PRESCALE`-1.
  - `anode` = ~(1<<slot) if `digit_en[slot]`=1, else 4'b1111.
  - On terminal count: go to BLANK (macro on), or to DRIVE with slot+1 mod 4 (macro off).
- BLANK: `anode`=4'b1111 for `BLANK_CYCLES` clocks, then DRIVE with slot+1 mod 4. `slot` holds its previous value during BLANK.
- Frame boundary is any entry into DRIVE with slot 0 (from ARM, or wrap from slot 3).
  - If `update_req`=1 in the cycle before entry, latch all four inputs into the `_q` registers on that edge.
  - `update_ack`=1 in the first DRIVE-slot-0 cycle, coincident with `frame_start`.
- Handshake: the requester holds `update_req` until it sees `update_ack`, then drops it within one cycle. A request withdrawn before the boundary produces no latch and no ack. A request still high after ack is treated as a new request at the next boundary.
- Snapshot values never change mid-frame.
- `digit_en` is sampled every cycle. A change affects `anode` one cycle later and does not alter slot timing.
- Reset values: `anode`=4'b1111, `slot`=0, all `_q`=0, `update_ack`=0, `frame_start`=0, counters 0, state ARM.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset release to first `anode`=4'b1110 (with `digit_en[0]`=1): 2 rising edges. The first edge enters ARM output, the second enters DRIVE.
- Digit period is `PRESCALE` cycles (macro off) or `PRESCALE`+`BLANK_CYCLES` (macro on). Frame period is 4× the digit period.
- Update latency: the ack pulse occurs 1 to 4×(digit period) cycles after `update_req` rises.
- Asynchronous reset mid-frame immediately forces all reset values. A pending request is discarded with no ack.
- `update_req` and a wrap from slot 3 in the same cycle: the latch takes effect on that wrap.

## Configuration
- `SCAN_BLANK_EN` defined: BLANK state and `BLANK_CYCLES` are active. All anodes are off between digits.
- `SCAN_BLANK_EN` undefined: there is no BLANK state and the `BLANK_CYCLES` counter is not built. Digits are back to back and `anode` changes directly between one-cold codes.

## Test plan
All scenarios use `PRESCALE`=4 and `BLANK_CYCLES`=2.
- **Reset/scan, macro off, `digit_en`=4'b1111.** Release reset → `anode` sequence 1111 (ARM), then 1110×4, 1101×4, 1011×4, 0111×4, 1110. `frame_start` pulses every 16 cycles.
- **Blanking, macro on.** Expect 1110×4, 1111×2, 1101×4, 1111×2 and so on. Frame is 24 cycles; `slot` is held during blank.
- **Handshake.** Set `A`=5, `B`=3, `AplusB`=8, `AminusB`=2 and raise `update_req` mid slot 1 → `_q` values stay at 0 until the wrap. Then `_q`=5/3/8/2 with `update_ack` and `frame_start` high in the same cycle. Drop req → no further ack.
- **Withdrawn request.** Pulse `update_req` for one cycle during slot 2, low at the boundary → no ack, `_q` unchanged. Inputs changing mid-frame → `_q` stable.
- **Digit mask.** `digit_en`=4'b0101 → `anode` 1110 in slot 0, 1111 in slot 1, 1011 in slot 2, 1111 in slot 3. Slot timing is unchanged.
- **Mid-operation reset.** Assert `rst_n`=0 in slot 2 with req pending → `anode`=1111 and `_q`=0 asynchronously, no ack. Release → ARM, then slot 0.
